// File: rtl/fixed_float_mul_if.sv
// Operand/result bundle between the CORDIC result path and the fixed-to-float multiplier.
interface fixed_float_mul_if #(
   parameter int CORDIC_DATA_WIDTH = 22
);
   logic                         clk_en;
   logic                         start;
   logic [CORDIC_DATA_WIDTH-1:0] fixed_in;
   logic [31:0]                  scale_in;
   logic [31:0]                  fixed_float;
   logic [31:0]                  product;
   logic                         done;
   logic                         busy;

   modport master (output clk_en, start, fixed_in, scale_in,
                   input  fixed_float, product, done, busy);
   modport slave  (input  clk_en, start, fixed_in, scale_in,
                   output fixed_float, product, done, busy);
endinterface

// File: rtl/fixed_float_mul_unit.sv
// Signed fixed-point to IEEE single conversion (C1..C4) followed by an IEEE single
// multiply with round-to-nearest-even (M1..M4); one operation per enabled cycle.
module fixed_float_mul_unit #(
   parameter int FLOAT_DATA_WIDTH  = 32,
   parameter int INTEGER_WIDTH     = 2,
   parameter int FRACTIONAL_WIDTH  = 20,
   parameter int CORDIC_DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH
) (
   input logic              clk,
   input logic              rst,
   fixed_float_mul_if.slave bus
);
   localparam int CW = CORDIC_DATA_WIDTH;
   localparam int FW = FLOAT_DATA_WIDTH;

   // bit 0 is stage C1, bit 7 is stage M4 (the output registers)
   logic [7:0]        vld_q, vld_d;
   logic [FW-1:0]     fixed_float_q, fixed_float_d, product_q, product_d;

   logic              c1_sign_q, c1_sign_d;
   logic [CW-1:0]     c1_mag_q, c1_mag_d;
   logic [FW-1:0]     c1_scale_q, c1_scale_d;
   logic              c2_sign_q, c2_sign_d, c2_zero_q, c2_zero_d;
   logic [CW-1:0]     c2_mag_q, c2_mag_d;
   logic [4:0]        c2_lead_q, c2_lead_d;
   logic [FW-1:0]     c2_scale_q, c2_scale_d;
   logic              c3_sign_q, c3_sign_d, c3_zero_q, c3_zero_d;
   logic [7:0]        c3_exp_q, c3_exp_d;
   logic [22:0]       c3_mant_q, c3_mant_d;
   logic [FW-1:0]     c3_scale_q, c3_scale_d;
   logic [FW-1:0]     c4_float_q, c4_float_d, c4_scale_q, c4_scale_d;

   logic              m1_sign_q, m1_sign_d, m1_nan_q, m1_nan_d;
   logic              m1_inf_q, m1_inf_d, m1_zero_q, m1_zero_d;
   logic signed [9:0] m1_exp_q, m1_exp_d;
   logic [23:0]       m1_ma_q, m1_ma_d, m1_mb_q, m1_mb_d;
   logic [FW-1:0]     m1_fixed_q, m1_fixed_d;
   logic              m2_sign_q, m2_sign_d, m2_nan_q, m2_nan_d;
   logic              m2_inf_q, m2_inf_d, m2_zero_q, m2_zero_d;
   logic signed [9:0] m2_exp_q, m2_exp_d;
   logic [47:0]       m2_prod_q, m2_prod_d;
   logic [FW-1:0]     m2_fixed_q, m2_fixed_d;
   logic              m3_sign_q, m3_sign_d, m3_nan_q, m3_nan_d;
   logic              m3_inf_q, m3_inf_d, m3_zero_q, m3_zero_d;
   logic signed [9:0] m3_exp_q, m3_exp_d;
   logic [22:0]       m3_mant_q, m3_mant_d;
   logic [FW-1:0]     m3_fixed_q, m3_fixed_d;

   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [23:0]       mant_t;
   logic              guard, sticky;
   logic [24:0]       rnd;
   logic signed [9:0] exp_t;

   always_comb begin
      vld_d = bus.clk_en ? {vld_q[6:0], bus.start} : vld_q;

      c1_sign_d  = bus.fixed_in[CW-1];
      c1_mag_d   = bus.fixed_in[CW-1] ? -bus.fixed_in : bus.fixed_in;
      c1_scale_d = bus.scale_in;

      c2_sign_d  = c1_sign_q;
      c2_mag_d   = c1_mag_q;
      c2_scale_d = c1_scale_q;
      c2_zero_d  = (c1_mag_q == '0);
      c2_lead_d  = 5'd0;
      for (int i = 0; i < CW; i++)
         if (c1_mag_q[i]) c2_lead_d = 5'(i);

      // leading one is shifted out of the 23-bit fraction field
      c3_sign_d  = c2_sign_q;
      c3_zero_d  = c2_zero_q;
      c3_scale_d = c2_scale_q;
      c3_mant_d  = 23'(c2_mag_q) << (5'd23 - c2_lead_q);
      c3_exp_d   = 8'(127 + int'(c2_lead_q) - FRACTIONAL_WIDTH);

      c4_float_d = c3_zero_q ? '0 : {c3_sign_q, c3_exp_q, c3_mant_q};
      c4_scale_d = c3_scale_q;

      a_nan  = (c4_float_q[30:23] == 8'hFF) && (c4_float_q[22:0] != '0);
      b_nan  = (c4_scale_q[30:23] == 8'hFF) && (c4_scale_q[22:0] != '0);
      a_inf  = (c4_float_q[30:23] == 8'hFF);
      b_inf  = (c4_scale_q[30:23] == 8'hFF);
      a_zero = (c4_float_q[30:23] == 8'h00);
      b_zero = (c4_scale_q[30:23] == 8'h00);
      m1_sign_d  = c4_float_q[31] ^ c4_scale_q[31];
      m1_nan_d   = a_nan | b_nan;
      m1_inf_d   = a_inf | b_inf;
      m1_zero_d  = a_zero | b_zero;
      m1_exp_d   = $signed({2'b00, c4_float_q[30:23]} + {2'b00, c4_scale_q[30:23]} - 10'd127);
      m1_ma_d    = {1'b1, c4_float_q[22:0]};
      m1_mb_d    = {1'b1, c4_scale_q[22:0]};
      m1_fixed_d = c4_float_q;

      m2_sign_d  = m1_sign_q;
      m2_nan_d   = m1_nan_q;
      m2_inf_d   = m1_inf_q;
      m2_zero_d  = m1_zero_q;
      m2_exp_d   = m1_exp_q;
      m2_prod_d  = 48'(m1_ma_q) * 48'(m1_mb_q);
      m2_fixed_d = m1_fixed_q;

      if (m2_prod_q[47]) begin
         mant_t = m2_prod_q[47:24];
         guard  = m2_prod_q[23];
         sticky = |m2_prod_q[22:0];
         exp_t  = m2_exp_q + 10'sd1;
      end else begin
         mant_t = m2_prod_q[46:23];
         guard  = m2_prod_q[22];
         sticky = |m2_prod_q[21:0];
         exp_t  = m2_exp_q;
      end
      rnd = {1'b0, mant_t} + 25'(guard & (sticky | mant_t[0]));
      m3_sign_d  = m2_sign_q;
      m3_nan_d   = m2_nan_q;
      m3_inf_d   = m2_inf_q;
      m3_zero_d  = m2_zero_q;
      m3_fixed_d = m2_fixed_q;
      m3_exp_d   = rnd[24] ? exp_t + 10'sd1 : exp_t;
      m3_mant_d  = rnd[24] ? rnd[23:1] : rnd[22:0];

      fixed_float_d = fixed_float_q;
      product_d     = product_q;
      if (bus.clk_en && vld_q[6]) begin
         fixed_float_d = m3_fixed_q;
         if (m3_nan_q || (m3_inf_q && m3_zero_q)) product_d = 32'h7FC0_0000;
         else if (m3_inf_q)                       product_d = {m3_sign_q, 8'hFF, 23'd0};
         else if (m3_zero_q)                      product_d = {m3_sign_q, 31'd0};
         else if (m3_exp_q >= 10'sd255)           product_d = {m3_sign_q, 8'hFF, 23'd0};
         else if (m3_exp_q <= 10'sd0)             product_d = {m3_sign_q, 31'd0};
         else                                     product_d = {m3_sign_q, m3_exp_q[7:0], m3_mant_q};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q         <= '0;
         fixed_float_q <= '0;
         product_q     <= '0;
      end else begin
         vld_q         <= vld_d;
         fixed_float_q <= fixed_float_d;
         product_q     <= product_d;
      end
   end

   // datapath carries no reset: only valid-qualified values ever reach the outputs
   always_ff @(posedge clk) begin
      if (bus.clk_en) begin
         c1_sign_q  <= c1_sign_d;  c1_mag_q  <= c1_mag_d;  c1_scale_q <= c1_scale_d;
         c2_sign_q  <= c2_sign_d;  c2_mag_q  <= c2_mag_d;  c2_scale_q <= c2_scale_d;
         c2_zero_q  <= c2_zero_d;  c2_lead_q <= c2_lead_d;
         c3_sign_q  <= c3_sign_d;  c3_zero_q <= c3_zero_d; c3_scale_q <= c3_scale_d;
         c3_exp_q   <= c3_exp_d;   c3_mant_q <= c3_mant_d;
         c4_float_q <= c4_float_d; c4_scale_q <= c4_scale_d;
         m1_sign_q  <= m1_sign_d;  m1_nan_q  <= m1_nan_d;  m1_inf_q   <= m1_inf_d;
         m1_zero_q  <= m1_zero_d;  m1_exp_q  <= m1_exp_d;  m1_fixed_q <= m1_fixed_d;
         m1_ma_q    <= m1_ma_d;    m1_mb_q   <= m1_mb_d;
         m2_sign_q  <= m2_sign_d;  m2_nan_q  <= m2_nan_d;  m2_inf_q   <= m2_inf_d;
         m2_zero_q  <= m2_zero_d;  m2_exp_q  <= m2_exp_d;  m2_fixed_q <= m2_fixed_d;
         m2_prod_q  <= m2_prod_d;
         m3_sign_q  <= m3_sign_d;  m3_nan_q  <= m3_nan_d;  m3_inf_q   <= m3_inf_d;
         m3_zero_q  <= m3_zero_d;  m3_exp_q  <= m3_exp_d;  m3_fixed_q <= m3_fixed_d;
         m3_mant_q  <= m3_mant_d;
      end
   end

   assign bus.fixed_float = fixed_float_q;
   assign bus.product     = product_q;
   assign bus.done        = vld_q[7];
   assign bus.busy        = |vld_q;
endmodule

// File: tb/tb_fixed_float_mul_unit.sv
// Directed plus random checks of fixed_float_mul_unit against a real-arithmetic reference model.
module tb_fixed_float_mul_unit;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   fixed_float_mul_if #(.CORDIC_DATA_WIDTH(22)) bus ();

   fixed_float_mul_unit dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // in-flight operations, oldest first; age counts enabled edges since launch
   int          age_q[$];
   logic [31:0] ff_q[$];
   logic [31:0] pr_q[$];
   logic [31:0] exp_ff = '0;
   logic [31:0] exp_pr = '0;
   logic        exp_done = 1'b0;

   function automatic logic [31:0] ref_conv(input logic [21:0] fx);
      int  sv;
      int  e;
      real v;
      if (fx == 22'd0) return 32'd0;
      sv = int'($signed(fx));
      v  = real'(sv) / 1048576.0;
      if (v < 0.0) v = -v;
      e = 0;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0)  begin v = v * 2.0; e--; end
      return {fx[21], 8'(127 + e), 23'($rtoi((v - 1.0) * 8388608.0))};
   endfunction

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int   ea, eb, e, fl;
      real  m, fr;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
      if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC0_0000;
      if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
      if (ea == 0 || eb == 0) return {s, 31'd0};
      m = (1.0 + real'(a[22:0]) / 8388608.0) * (1.0 + real'(b[22:0]) / 8388608.0);
      e = ea + eb - 254;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      m  = m * 8388608.0;
      fl = $rtoi(m);
      fr = m - real'(fl);
      if (fr > 0.5 || (fr == 0.5 && fl[0])) fl++;
      if (fl == 16777216) begin fl = 8388608; e++; end
      if (e + 127 >= 255) return {s, 8'hFF, 23'd0};
      if (e + 127 <= 0) return {s, 31'd0};
      return {s, 8'(e + 127), 23'(fl - 8388608)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic st, input logic [21:0] fx, input logic [31:0] sc,
                       input logic en, input logic rb);
      bus.start    = st;
      bus.fixed_in = fx;
      bus.scale_in = sc;
      bus.clk_en   = en;
      rst          = rb;
      @(posedge clk);
      cyc++;
      if (!rb) begin
         age_q.delete(); ff_q.delete(); pr_q.delete();
         exp_ff = '0; exp_pr = '0; exp_done = 1'b0;
      end else if (en) begin
         if (age_q.size() > 0 && age_q[0] == 8) begin
            void'(age_q.pop_front()); void'(ff_q.pop_front()); void'(pr_q.pop_front());
         end
         foreach (age_q[i]) age_q[i]++;
         if (st) begin
            age_q.push_back(1);
            ff_q.push_back(ref_conv(fx));
            pr_q.push_back(ref_mul(ref_conv(fx), sc));
         end
         exp_done = (age_q.size() > 0 && age_q[0] == 8);
         if (exp_done) begin exp_ff = ff_q[0]; exp_pr = pr_q[0]; end
      end
      #1;
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("busy", 32'(bus.busy), 32'(age_q.size() != 0));
      chk("fixed_float", bus.fixed_float, exp_ff);
      chk("product", bus.product, exp_pr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 22'd0, 32'd0, 1'b1, 1'b1);
   endtask

   task automatic directed(input logic [21:0] fx, input logic [31:0] sc,
                           input logic [31:0] want_ff, input logic [31:0] want_pr);
      int n;
      step(1'b1, fx, sc, 1'b1, 1'b1);
      n = 1;
      while (!bus.done && n < 12) begin
         step(1'b0, 22'd0, 32'd0, 1'b1, 1'b1);
         n++;
      end
      chk("latency", 32'(n), 32'd8);
      chk("const_ff", bus.fixed_float, want_ff);
      chk("const_pr", bus.product, want_pr);
   endtask

   function automatic logic [21:0] rnd_fixed();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0:       return 22'd0;
         1:       return 22'h200000;
         2:       return 22'($urandom_range(1, 15));
         3:       return 22'h1FFFFF;
         default: return r[21:0];
      endcase
   endfunction

   function automatic logic [31:0] rnd_scale();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 19))
         0:       return {r[31], 31'd0};
         1:       return {r[31], 8'h00, r[22:0]};
         2:       return {r[31], 8'hFF, 23'd0};
         3:       return {r[31], 8'hFF, r[22:1], 1'b1};
         4, 5:    return {r[31], 8'($urandom_range(230, 254)), r[22:0]};
         6, 7:    return {r[31], 8'($urandom_range(1, 40)), r[22:0]};
         default: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
      endcase
   endfunction

   initial begin
      int          s;
      int          n_done;
      int          dq[$];
      logic [31:0] pq[$];
      bus.clk_en = 1'b0; bus.start = 1'b0; bus.fixed_in = '0; bus.scale_in = '0; rst = 1'b0;

      // reset, including a start presented while reset is asserted
      step(1'b0, 22'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, 22'h100000, 32'h4000_0000, 1'b1, 1'b0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_pr", bus.product, 32'd0);
      idle(2);

      directed(22'h100000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000);
      directed(22'h300000, 32'h3F00_0000, 32'hBF80_0000, 32'hBF00_0000);
      directed(22'h000001, 32'h3F80_0000, 32'h3580_0000, 32'h3580_0000);
      directed(22'h000000, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
      directed(22'h200000, 32'h7F00_0000, 32'hC000_0000, 32'hFF80_0000);
      idle(2);

      // three back-to-back launches with a two-cycle stall while all are in flight
      s = cyc + 1;
      step(1'b1, 22'h100000, 32'h4000_0000, 1'b1, 1'b1);
      step(1'b1, 22'h300000, 32'h3F00_0000, 1'b1, 1'b1);
      step(1'b1, 22'h000001, 32'h3F80_0000, 1'b1, 1'b1);
      step(1'b1, 22'h100000, 32'h4000_0000, 1'b0, 1'b1);
      step(1'b0, 22'd0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 22'd0, 32'd0, 1'b1, 1'b1);
         if (bus.done) begin dq.push_back(cyc - s); pq.push_back(bus.product); end
      end
      chk("stall_ndone", 32'(dq.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < dq.size()) begin
            chk("stall_when", 32'(dq[i]), 32'(9 + i));
            chk("stall_order", pq[i], (i == 0) ? 32'h4000_0000 : (i == 1) ? 32'hBF00_0000 : 32'h3580_0000);
         end
      end

      // reset on the fourth edge after a launch discards the operation
      step(1'b1, 22'h100000, 32'h4000_0000, 1'b1, 1'b1);
      idle(2);
      step(1'b0, 22'd0, 32'd0, 1'b1, 1'b0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_ff", bus.fixed_float, 32'd0);
      chk("midrst_pr", bus.product, 32'd0);
      n_done = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 22'd0, 32'd0, 1'b1, 1'b1);
         if (bus.done) n_done++;
      end
      chk("midrst_nodone", 32'(n_done), 32'd0);
      directed(22'h100000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000);

      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 9) < 7), rnd_fixed(), rnd_scale(),
              1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 99) != 0));
      idle(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
